// File: rtl/mcp_rx_ctrl.sv
// Multi-channel MCP receive controller in the clk_b domain: toggle sync, edge detect, capture, ack.
// Optional macro MCP_RX_OVERRUN_DET_EN adds sticky per-channel overrun flags (b_ovr / ovr_clr).
module mcp_rx_ctrl #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AUTO_LOAD   = 0
) (
    input  logic              clk_b,
    input  logic              rst_b,
    input  logic [NCH-1:0]    a_req_tgl,
    input  logic [NCH*DW-1:0] a_data,
    input  logic [NCH-1:0]    bload,
    output logic [NCH-1:0]    bvalid,
    output logic [NCH*DW-1:0] b_data,
    output logic [NCH-1:0]    b_ack_tgl
`ifdef MCP_RX_OVERRUN_DET_EN
   ,output logic [NCH-1:0]    b_ovr,
    input  logic [NCH-1:0]    ovr_clr
`endif
);

    typedef enum logic {ST_WAIT = 1'b0, ST_READY = 1'b1} state_e;

    state_e                          state_q [NCH];
    state_e                          state_d [NCH];
    logic [NCH-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NCH-1:0]                  edge_q;
    logic [NCH-1:0]                  req_evt;
    logic [NCH-1:0]                  load;
    logic [NCH-1:0]                  pend_q, pend_d;
    logic [NCH-1:0]                  ack_q, ack_d;
    logic [NCH*DW-1:0]               data_q, data_d;
`ifdef MCP_RX_OVERRUN_DET_EN
    logic [NCH-1:0]                  ovr_q, ovr_d;
`endif

    assign load = (AUTO_LOAD != 0) ? '1 : bload;

    always_comb begin
        req_evt = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            req_evt[c] = sync_q[c][SYNC_STAGES-1] ^ edge_q[c];
        end
    end

    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            sync_q <= '0;
            edge_q <= '0;
            pend_q <= '0;
            ack_q  <= '0;
            data_q <= '0;
`ifdef MCP_RX_OVERRUN_DET_EN
            ovr_q  <= '0;
`endif
            for (int unsigned c = 0; c < NCH; c++) begin
                state_q[c] <= ST_WAIT;
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                sync_q[c]  <= {sync_q[c][SYNC_STAGES-2:0], a_req_tgl[c]};
                edge_q[c]  <= sync_q[c][SYNC_STAGES-1];
                state_q[c] <= state_d[c];
            end
            pend_q <= pend_d;
            ack_q  <= ack_d;
            data_q <= data_d;
`ifdef MCP_RX_OVERRUN_DET_EN
            ovr_q  <= ovr_d;
`endif
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_WAIT:  if (req_evt[c] || pend_q[c]) state_d[c] = ST_READY;
                ST_READY: if (load[c])                 state_d[c] = ST_WAIT;
                default:                               state_d[c] = ST_WAIT;
            endcase
        end
    end

    // A request seen while READY is parked in pend and replayed after one WAIT cycle.
    always_comb begin
        bvalid = '0;
        pend_d = pend_q;
        ack_d  = ack_q;
        data_d = data_q;
`ifdef MCP_RX_OVERRUN_DET_EN
        ovr_d  = ovr_q & ~ovr_clr;
`endif
        for (int unsigned c = 0; c < NCH; c++) begin
            bvalid[c] = (state_q[c] == ST_READY);
            if (state_q[c] == ST_WAIT) begin
                if (req_evt[c] || pend_q[c]) begin
                    data_d[c*DW +: DW] = a_data[c*DW +: DW];
                    pend_d[c]          = 1'b0;
                end
            end else begin
                if (load[c]) begin
                    ack_d[c] = ~ack_q[c];
                end
                if (req_evt[c]) begin
                    if (!pend_q[c]) begin
                        pend_d[c] = 1'b1;
                    end
`ifdef MCP_RX_OVERRUN_DET_EN
                    else begin
                        ovr_d[c] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    assign b_data    = data_q;
    assign b_ack_tgl = ack_q;
`ifdef MCP_RX_OVERRUN_DET_EN
    assign b_ovr     = ovr_q;
`endif

endmodule
